// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 8-bit ALU with result register, flags, 8-cycle shift-add multiply and tri-state bus drive
// Optional ALU_FLAGS_BUS_EN adds flags_outn to place {C,Z,N,V} on the bus.
module alu_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] alu_l,
   input  logic [WIDTH-1:0] alu_r,
   input  logic [2:0]       op,
   input  logic             cin,
   input  logic             calcn,
   input  logic             outn,
`ifdef ALU_FLAGS_BUS_EN
   input  logic             flags_outn,
`endif
   inout  wire  [WIDTH-1:0] bus,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [3:0]           flags_q, flags_d;
   logic                 busy_q, busy_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2:0]           cnt_q, cnt_d;

   logic [WIDTH-1:0]     addend;
   logic                 carry;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic [2*WIDTH-1:0]   acc_step;

   // Subtraction is l + ~r + carry, so C=1 means no borrow.
   always_comb begin
      addend = alu_r;
      carry  = 1'b0;
      case (op)
         OP_ADC:  carry = cin;
         OP_SUB:  begin addend = ~alu_r; carry = 1'b1; end
         OP_SBC:  begin addend = ~alu_r; carry = cin;  end
         default: ;
      endcase
      sum = {1'b0, alu_l} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};

      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_v   = (alu_l[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != alu_l[WIDTH-1]);
      case (op)
         OP_AND:  begin alu_res = alu_l & alu_r; alu_c = 1'b0; alu_v = 1'b0; end
         OP_OR:   begin alu_res = alu_l | alu_r; alu_c = 1'b0; alu_v = 1'b0; end
         OP_XOR:  begin alu_res = alu_l ^ alu_r; alu_c = 1'b0; alu_v = 1'b0; end
         default: ;
      endcase

      acc_step = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      busy_d   = busy_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!calcn) begin
               if (op == OP_MUL) begin
                  a_d     = alu_l;
                  b_d     = alu_r;
                  acc_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = S_MUL;
               end else begin
                  result_d = alu_res;
                  flags_d  = {alu_c, alu_res == '0, alu_res[WIDTH-1], alu_v};
               end
            end
         end
         S_MUL: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(WIDTH-1)) begin
               result_d = acc_step[WIDTH-1:0];
               flags_d  = {|acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1:0] == '0,
                           acc_step[WIDTH-1], 1'b0};
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
         busy_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         busy_q   <= busy_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign flags = flags_q;
   assign busy  = busy_q;

   // Result output enable wins if both enables are asserted.
`ifdef ALU_FLAGS_BUS_EN
   assign bus = !outn       ? result_q :
                !flags_outn ? {{(WIDTH-4){1'b0}}, flags_q} : {WIDTH{1'bz}};
`else
   assign bus = !outn ? result_q : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit: vector table, corner sequences, random vs model
module tb_alu_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] alu_l = 8'h00;
   logic [7:0] alu_r = 8'h00;
   logic [2:0] op = 3'd0;
   logic       cin = 1'b0;
   logic       calcn = 1'b1;
   logic       outn = 1'b0;
   wire  [7:0] bus;
   logic [3:0] flags;
   logic       busy;
`ifdef ALU_FLAGS_BUS_EN
   logic       flags_outn = 1'b1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Undriven bus reads as all ones.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus[g]);
   end

   alu_unit dut (
      .clk   (clk),
      .reset (reset),
      .alu_l (alu_l),
      .alu_r (alu_r),
      .op    (op),
      .cin   (cin),
      .calcn (calcn),
      .outn  (outn),
`ifdef ALU_FLAGS_BUS_EN
      .flags_outn (flags_outn),
`endif
      .bus   (bus),
      .flags (flags),
      .busy  (busy)
   );

`ifdef ALU_FLAGS_BUS_EN
   always @(negedge clk) assert (!(!outn && !flags_outn));
`endif

   typedef struct {
      logic [7:0] l;
      logic [7:0] r;
      logic [2:0] op;
      logic       cin;
      logic [7:0] res;
      logic [3:0] fl;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: {flags, result} from plain integer arithmetic.
   function automatic logic [11:0] model(input logic [7:0] l, input logic [7:0] r,
                                         input logic [2:0] o, input logic c);
      int ul, ur, sl, sr, u, s;
      logic [7:0] res;
      logic fc, fv;
      ul = l; ur = r;
      sl = $signed(l); sr = $signed(r);
      u = 0; s = 0; fc = 1'b0; fv = 1'b0;
      case (o)
         3'd0: begin u = ul + ur;              s = sl + sr;             end
         3'd1: begin u = ul + ur + c;          s = sl + sr + c;         end
         3'd2: begin u = ul + (255 - ur) + 1;  s = sl - sr;             end
         3'd3: begin u = ul + (255 - ur) + c;  s = sl - sr - 1 + c;     end
         3'd4: u = ul & ur;
         3'd5: u = ul | ur;
         3'd6: u = ul ^ ur;
         default: u = ul * ur;
      endcase
      res = u[7:0];
      if (o <= 3'd3) begin
         fc = (u > 255);
         fv = (s > 127) || (s < -128);
      end else if (o == 3'd7) begin
         fc = (u > 255);
      end
      return {fc, res == 8'h00, res[7], fv, res};
   endfunction

   task automatic pulse(input logic [7:0] l, input logic [7:0] r, input logic [2:0] o, input logic c);
      @(negedge clk);
      alu_l = l; alu_r = r; op = o; cin = c; calcn = 1'b0;
      @(negedge clk);
      calcn = 1'b1;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   initial begin
      int cyc;
      logic [11:0] exp;
      logic [7:0] rl, rr;
      logic [2:0] ro;
      logic rc;

      vecs[0]  = '{8'h7F, 8'h01, 3'd0, 1'b0, 8'h80, 4'b0011};
      vecs[1]  = '{8'h05, 8'h05, 3'd2, 1'b0, 8'h00, 4'b1100};
      vecs[2]  = '{8'h03, 8'h05, 3'd2, 1'b0, 8'hFE, 4'b0010};
      vecs[3]  = '{8'hFF, 8'h00, 3'd1, 1'b1, 8'h00, 4'b1100};
      vecs[4]  = '{8'hFF, 8'h00, 3'd3, 1'b0, 8'hFE, 4'b1010};
      vecs[5]  = '{8'h80, 8'h01, 3'd2, 1'b0, 8'h7F, 4'b1001};
      vecs[6]  = '{8'hF0, 8'h3C, 3'd4, 1'b0, 8'h30, 4'b0000};
      vecs[7]  = '{8'hF0, 8'h3C, 3'd5, 1'b0, 8'hFC, 4'b0010};
      vecs[8]  = '{8'h0C, 8'h0B, 3'd7, 1'b0, 8'h84, 4'b0010};
      vecs[9]  = '{8'h20, 8'h10, 3'd7, 1'b0, 8'h00, 4'b1100};
      vecs[10] = '{8'hF0, 8'h3C, 3'd6, 1'b0, 8'hCC, 4'b0010};

      @(negedge clk);
      @(negedge clk);
      check("reset_bus", {8'h00, bus}, 16'h0000);
      check("reset_flags", {12'h000, flags}, 16'h0000);
      check("reset_busy", {15'h0000, busy}, 16'h0000);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         pulse(vecs[i].l, vecs[i].r, vecs[i].op, vecs[i].cin);
         if (vecs[i].op == 3'd7) begin
            wait_idle(cyc);
            check("vec_mul_busy_cycles", 16'(cyc), 16'd8);
         end
         check("vec_result", {8'h00, bus}, {8'h00, vecs[i].res});
         check("vec_flags", {12'h000, flags}, {12'h000, vecs[i].fl});
      end

      // Hold: calcn high with changing inputs keeps 0xCC.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         alu_l = 8'(i * 37 + 1); alu_r = 8'(i * 11 + 5); op = 3'(i);
         check("hold_result", {8'h00, bus}, 16'h00CC);
      end

      outn = 1'b1;
      #1 check("bus_released", {8'h00, bus}, 16'h00FF);
      outn = 1'b0;
      #1 check("bus_driven", {8'h00, bus}, 16'h00CC);

      // Compute strobes during a multiply are ignored; operands may change.
      pulse(8'h0C, 8'h0B, 3'd7, 1'b0);
      check("mul_busy_start", {15'h0000, busy}, 16'h0001);
      alu_l = 8'h55; alu_r = 8'hAA; op = 3'd4; calcn = 1'b0;
      @(negedge clk);
      check("mul_hold_result", {8'h00, bus}, 16'h00CC);
      @(negedge clk);
      calcn = 1'b1;
      wait_idle(cyc);
      check("mul_ignore_busy_cycles", 16'(cyc), 16'd6);
      check("mul_ignore_result", {8'h00, bus}, 16'h0084);
      check("mul_ignore_flags", {12'h000, flags}, 16'h0002);

      // Continuous calcn low: one operation per edge.
      @(negedge clk);
      alu_l = 8'h01; alu_r = 8'h01; op = 3'd0; calcn = 1'b0;
      @(negedge clk);
      check("back2back_1", {8'h00, bus}, 16'h0002);
      alu_l = 8'h02; alu_r = 8'h03;
      @(negedge clk);
      check("back2back_2", {8'h00, bus}, 16'h0005);
      calcn = 1'b1;

      // Asynchronous reset in the middle of a multiply.
      pulse(8'h0F, 8'h03, 3'd7, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", {15'h0000, busy}, 16'h0000);
      check("rst_mid_bus", {8'h00, bus}, 16'h0000);
      check("rst_mid_flags", {12'h000, flags}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_no_partial", {7'h00, busy, bus}, 16'h0000);

      for (int i = 0; i < 200; i++) begin
         rl = 8'($urandom); rr = 8'($urandom);
         ro = 3'($urandom_range(0, 7)); rc = 1'($urandom);
         exp = model(rl, rr, ro, rc);
         pulse(rl, rr, ro, rc);
         alu_l = 8'($urandom); alu_r = 8'($urandom);
         if (ro == 3'd7) begin
            wait_idle(cyc);
            check("rand_mul_cycles", 16'(cyc), 16'd8);
         end
         check("rand_result", {8'h00, bus}, {8'h00, exp[7:0]});
         check("rand_flags", {12'h000, flags}, {12'h000, exp[11:8]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
